// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPRAM arbiter.
//   SPRAM_ADDR_W / SPRAM_DATA_W : default word-address / data widths (16K x 16)
//   P_SPI / P_LOCAL             : port indices (SPI engine, local fabric master)
//   WAIT_W                      : width of the port 1 starvation counter
package spi_ram_pkg;

    localparam int   SPRAM_ADDR_W = 14;
    localparam int   SPRAM_DATA_W = 16;
    localparam int   WAIT_W       = 16;

    localparam logic P_SPI   = 1'b0;
    localparam logic P_LOCAL = 1'b1;

endpackage

// File: rtl/spi_ram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk : clock
//   i_clr : synchronous clear, wins over i_inc
//   i_inc : count enable; the count holds at all-ones
//   o_cnt : current count
module sat_counter
    import spi_ram_pkg::*;
#(
    parameter int WIDTH = WAIT_W
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Single-stage arbiter between the SPI-slave RAM engine (port 0, fixed
// priority) and a local fabric master (port 1) in front of one SPRAM.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_pN_req/we/addr/wdata/mask, o_pN_ack/rdata : requester ports 0 and 1
//   i_p1_en                 : port 1 grant enable
//   o_mem_* / i_mem_rdata   : SPRAM interface (read data one cycle after cs)
//   o_p1_wait_cnt, i_p1_wait_clr : saturating port 1 starvation counter
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = SPRAM_ADDR_W,
    parameter int DATA_W = SPRAM_DATA_W
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_p0_req,
    input  logic                i_p0_we,
    input  logic [ADDR_W-1:0]   i_p0_addr,
    input  logic [DATA_W-1:0]   i_p0_wdata,
    input  logic [DATA_W/8-1:0] i_p0_mask,
    output logic                o_p0_ack,
    output logic [DATA_W-1:0]   o_p0_rdata,

    input  logic                i_p1_req,
    input  logic                i_p1_we,
    input  logic [ADDR_W-1:0]   i_p1_addr,
    input  logic [DATA_W-1:0]   i_p1_wdata,
    input  logic [DATA_W/8-1:0] i_p1_mask,
    output logic                o_p1_ack,
    output logic [DATA_W-1:0]   o_p1_rdata,
    input  logic                i_p1_en,

    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic                o_mem_we,
    output logic [DATA_W/4-1:0] o_mem_maskwren,
    output logic                o_mem_cs,
    input  logic [DATA_W-1:0]   i_mem_rdata,

    output logic [WAIT_W-1:0]   o_p1_wait_cnt,
    input  logic                i_p1_wait_clr
);

    // In-flight tag: valid in the cycle after a grant, which is also the
    // ack cycle of that access.
    logic r_tag_vld;
    logic r_tag_port;

    logic w_p0_busy, w_p1_busy;
    logic w_p0_elig, w_p1_elig;
    logic w_gnt0, w_gnt1;
    logic w_wait_inc;
    logic [DATA_W/8-1:0] w_mask_sel;

    assign w_p0_busy = r_tag_vld && (r_tag_port == P_SPI);
    assign w_p1_busy = r_tag_vld && (r_tag_port == P_LOCAL);

    assign w_p0_elig = i_p0_req && !w_p0_busy;
    assign w_p1_elig = i_p1_req && i_p1_en && !w_p1_busy;

    assign w_gnt0 = w_p0_elig;
    assign w_gnt1 = !w_p0_elig && w_p1_elig;

    // Grant is presented to the SPRAM combinationally; reset does not gate
    // it, so a write granted in a reset cycle still lands.
    always_comb begin
        o_mem_addr  = i_p0_addr;
        o_mem_wdata = i_p0_wdata;
        w_mask_sel  = i_p0_mask;
        o_mem_we    = 1'b0;
        o_mem_cs    = 1'b0;
        if (w_gnt0) begin
            o_mem_cs = 1'b1;
            o_mem_we = i_p0_we;
        end else if (w_gnt1) begin
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
            w_mask_sel  = i_p1_mask;
            o_mem_cs    = 1'b1;
            o_mem_we    = i_p1_we;
        end
    end

    // SPRAM masks per nibble: each byte enable drives two nibble enables.
    for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_mask
        assign o_mem_maskwren[2*gi +: 2] = {2{w_mask_sel[gi]}};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_vld  <= 1'b0;
            r_tag_port <= P_SPI;
        end else begin
            r_tag_vld  <= w_gnt0 || w_gnt1;
            r_tag_port <= w_gnt1 ? P_LOCAL : P_SPI;
        end
    end

    // Masking with reset drops an access that is in its ack cycle when
    // reset arrives.
    assign o_p0_ack   = w_p0_busy && !i_rst;
    assign o_p1_ack   = w_p1_busy && !i_rst;
    assign o_p0_rdata = i_mem_rdata;
    assign o_p1_rdata = i_mem_rdata;

    // Port 1 is counted as waiting only when it lost to port 0 while it
    // could otherwise have been granted.
    assign w_wait_inc = i_p1_req && i_p1_en && !w_p1_busy && w_gnt0;

    sat_counter #(
        .WIDTH(WAIT_W)
    ) u_wait_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst || i_p1_wait_clr),
        .i_inc (w_wait_inc),
        .o_cnt (o_p1_wait_cnt)
    );

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, p1_en, p1_wait_clr;
    logic [13:0] p0_addr, p1_addr, mem_addr;
    logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [1:0]  p0_mask, p1_mask;
    logic        p0_ack, p1_ack, mem_we, mem_cs;
    logic [3:0]  mem_maskwren;
    logic [15:0] p1_wait_cnt;

    spi_ram_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .i_p0_mask(p0_mask), .o_p0_ack(p0_ack), .o_p0_rdata(p0_rdata),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .i_p1_mask(p1_mask), .o_p1_ack(p1_ack), .o_p1_rdata(p1_rdata), .i_p1_en(p1_en),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .o_mem_maskwren(mem_maskwren), .o_mem_cs(mem_cs), .i_mem_rdata(mem_rdata),
        .o_p1_wait_cnt(p1_wait_cnt), .i_p1_wait_clr(p1_wait_clr)
    );

    // Standalone counter so saturation fits in a short run.
    logic        s_clr, s_inc;
    logic [15:0] s_cnt;
    sat_counter #(.WIDTH(16)) u_sat (.i_clk(clk), .i_clr(s_clr), .i_inc(s_inc), .o_cnt(s_cnt));

    // SPRAM behavioural model: nibble-masked write, registered read.
    logic [15:0] spram [0:16383];
    logic [15:0] spram_q = 16'h0;
    assign mem_rdata = spram_q;
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int n = 0; n < 4; n++)
                    if (mem_maskwren[n]) spram[mem_addr][4*n +: 4] <= mem_wdata[4*n +: 4];
            end else begin
                spram_q <= spram[mem_addr];
            end
        end
    end

    typedef struct {
        logic p0r, p0w; logic [13:0] p0a; logic [15:0] p0d; logic [1:0] p0m;
        logic p1r, p1w; logic [13:0] p1a; logic [15:0] p1d; logic [1:0] p1m;
        logic en;
        int   g;      // expected grant: 0 none, 1 port 0, 2 port 1
    } vec_t;

    typedef struct { int port; logic rd; logic [15:0] data; } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    logic [15:0] ref_mem [0:16383];
    int          prev_g = 0;
    int          n_chk = 0, n_err = 0;

    function automatic vec_t mk(input logic p0r, p0w, input logic [13:0] p0a, input logic [15:0] p0d,
                                input logic [1:0] p0m, input logic p1r, p1w, input logic [13:0] p1a,
                                input logic [15:0] p1d, input logic [1:0] p1m, input logic en, input int g);
        vec_t v;
        v.p0r = p0r; v.p0w = p0w; v.p0a = p0a; v.p0d = p0d; v.p0m = p0m;
        v.p1r = p1r; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d; v.p1m = p1m;
        v.en = en; v.g = g;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 14'h0, 16'h0, 2'b00, 0, 0, 14'h0, 16'h0, 2'b00, 1, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive, check at the falling edge, advance past the rising edge.
    task automatic step(input vec_t v);
        logic [13:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        logic        w;
        sb_t         e;
        p0_req = v.p0r; p0_we = v.p0w; p0_addr = v.p0a; p0_wdata = v.p0d; p0_mask = v.p0m;
        p1_req = v.p1r; p1_we = v.p1w; p1_addr = v.p1a; p1_wdata = v.p1d; p1_mask = v.p1m;
        p1_en  = v.en;
        @(negedge clk);
        chk("p0_ack", {31'd0, p0_ack}, {31'd0, prev_g == 1});
        chk("p1_ack", {31'd0, p1_ack}, {31'd0, prev_g == 2});
        if (p0_ack || p1_ack) begin
            if (sb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL sb_empty: ack with no expected access at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("ack_port", p1_ack ? 32'd2 : 32'd1, e.port);
                if (e.rd) chk("rdata", {16'h0, (e.port == 1) ? p0_rdata : p1_rdata}, {16'h0, e.data});
            end
        end
        chk("mem_cs", {31'd0, mem_cs}, {31'd0, v.g != 0});
        if (v.g != 0) begin
            if (v.g == 1) begin a = v.p0a; d = v.p0d; m = v.p0m; w = v.p0w; end
            else          begin a = v.p1a; d = v.p1d; m = v.p1m; w = v.p1w; end
            chk("mem_addr", {18'h0, mem_addr}, {18'h0, a});
            chk("mem_we", {31'd0, mem_we}, {31'd0, w});
            if (w) begin
                chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, d});
                chk("mem_maskwren", {28'h0, mem_maskwren}, {28'h0, m[1], m[1], m[0], m[0]});
                for (int b = 0; b < 2; b++)
                    if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                e.port = v.g; e.rd = 1'b0; e.data = 16'h0;
            end else begin
                e.port = v.g; e.rd = 1'b1; e.data = ref_mem[a];
            end
            sb.push_back(e);
        end else begin
            chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
        end
        prev_g = v.g;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic clr_cnt();
        p1_wait_clr = 1'b1;
        step(idle());
        p1_wait_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin spram[i] = 16'h0; ref_mem[i] = 16'h0; end
        rst = 1'b1; p1_wait_clr = 1'b0; s_clr = 1'b0; s_inc = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_mask = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_mask = '0; p1_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p0_ack", {31'd0, p0_ack}, 32'd0);
        chk("rst_p1_ack", {31'd0, p1_ack}, 32'd0);
        chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wait_cnt", {16'h0, p1_wait_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(idle());

        // Write/readback, byte mask, cross-port write-then-read, p1_en drop
        // while outstanding, pending p1 inputs changing before grant.
        tbl.push_back(mk(1, 1, 14'h10, 16'hBEEF, 2'b11, 0, 0, 14'h0, 16'h0, 2'b00, 1, 1));
        tbl.push_back(mk(1, 0, 14'h10, 16'h0, 2'b00, 0, 0, 14'h0, 16'h0, 2'b00, 1, 0));
        tbl.push_back(mk(1, 0, 14'h10, 16'h0, 2'b00, 0, 0, 14'h0, 16'h0, 2'b00, 1, 1));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 1, 14'h20, 16'h1234, 2'b11, 0, 0, 14'h0, 16'h0, 2'b00, 1, 1));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 1, 14'h20, 16'hAB00, 2'b10, 0, 0, 14'h0, 16'h0, 2'b00, 1, 1));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 0, 14'h20, 16'h0, 2'b00, 0, 0, 14'h0, 16'h0, 2'b00, 1, 1));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 1, 14'h30, 16'h55AA, 2'b11, 1, 0, 14'h30, 16'h0, 2'b00, 1, 1));
        tbl.push_back(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h30, 16'h0, 2'b00, 1, 2));
        tbl.push_back(idle());
        tbl.push_back(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h10, 16'h0, 2'b00, 1, 2));
        tbl.push_back(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h10, 16'h0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h10, 16'h0, 2'b00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 0, 14'h1, 16'h0, 2'b00, 1, 1, 14'h40, 16'h1111, 2'b11, 1, 1));
        tbl.push_back(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 1, 14'h41, 16'h2222, 2'b01, 1, 2));
        tbl.push_back(idle());
        run_tbl();

        // Simultaneous requests: p0 in N, p1 in N+1, one wait cycle counted.
        clr_cnt();
        step(mk(1, 0, 14'h1, 16'h0, 2'b00, 1, 0, 14'h2, 16'h0, 2'b00, 1, 1));
        step(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h2, 16'h0, 2'b00, 1, 2));
        step(idle());
        chk("wait_cnt_simul", {16'h0, p1_wait_cnt}, 32'd1);

        // Both ports at full rate: grants alternate. After the first
        // contest p1 is outstanding whenever p0 wins, so no further counts.
        clr_cnt();
        for (int k = 0; k < 6; k++)
            step(mk(1, 0, 14'(k), 16'h0, 2'b00, 1, 0, 14'(16'h100 + k), 16'h0, 2'b00, 1, (k % 2 == 0) ? 1 : 2));
        step(idle());
        step(idle());
        chk("wait_cnt_alt", {16'h0, p1_wait_cnt}, 32'd1);

        // p0 full rate, p1 enabled only in p0 grant cycles: counts every other cycle.
        clr_cnt();
        for (int k = 0; k < 6; k++)
            step(mk(1, 0, 14'(k), 16'h0, 2'b00, 1, 0, 14'h100, 16'h0, 2'b00, k % 2 == 0, (k % 2 == 0) ? 1 : 0));
        step(idle());
        chk("wait_cnt_toggle", {16'h0, p1_wait_cnt}, 32'd3);
        p1_wait_clr = 1'b1;
        step(mk(1, 0, 14'h1, 16'h0, 2'b00, 1, 0, 14'h100, 16'h0, 2'b00, 1, 1));
        p1_wait_clr = 1'b0;
        chk("wait_clr_prio", {16'h0, p1_wait_cnt}, 32'd0);
        step(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h100, 16'h0, 2'b00, 1, 2));
        step(idle());
        chk("wait_cnt_after_clr", {16'h0, p1_wait_cnt}, 32'd0);

        // p1_en low for a long stretch: never granted, never counted.
        clr_cnt();
        for (int k = 0; k < 2000; k++)
            step(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h41, 16'h0, 2'b00, 0, 0));
        chk("wait_cnt_disabled", {16'h0, p1_wait_cnt}, 32'd0);
        step(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h41, 16'h0, 2'b00, 1, 2));
        step(idle());
        chk("wait_cnt_enabled", {16'h0, p1_wait_cnt}, 32'd0);

        // Reset in the ack cycle of a p1 read drops the ack.
        clr_cnt();
        step(mk(1, 1, 14'h50, 16'h7777, 2'b11, 1, 0, 14'h20, 16'h0, 2'b00, 1, 1));
        step(mk(0, 0, 14'h0, 16'h0, 2'b00, 1, 0, 14'h20, 16'h0, 2'b00, 1, 2));
        chk("wait_cnt_pre_rst", {16'h0, p1_wait_cnt}, 32'd1);
        rst = 1'b1; p0_req = 0; p1_req = 0;
        @(negedge clk);
        chk("rst_drop_p1_ack", {31'd0, p1_ack}, 32'd0);
        chk("rst_drop_p0_ack", {31'd0, p0_ack}, 32'd0);
        chk("rst_mem_cs_mid", {31'd0, mem_cs}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        prev_g = 0;
        @(negedge clk);
        chk("post_rst_p1_ack", {31'd0, p1_ack}, 32'd0);
        chk("post_rst_wait_cnt", {16'h0, p1_wait_cnt}, 32'd0);
        @(posedge clk); #1;
        step(mk(1, 0, 14'h50, 16'h0, 2'b00, 0, 0, 14'h0, 16'h0, 2'b00, 1, 1));
        step(idle());

        // Saturation of the 16-bit counter.
        s_clr = 1'b1;
        @(posedge clk); #1;
        s_clr = 1'b0;
        chk("sat_clr", {16'h0, s_cnt}, 32'd0);
        s_inc = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'h0, s_cnt}, 32'hFFFE);
        @(posedge clk); #1;
        chk("sat_ffff", {16'h0, s_cnt}, 32'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_hold", {16'h0, s_cnt}, 32'hFFFF);
        s_clr = 1'b1;
        @(posedge clk); #1;
        s_clr = 1'b0; s_inc = 1'b0;
        chk("sat_clr_prio", {16'h0, s_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
